// File: rtl/irq_pkg.sv
// Shared constants, register offsets and types for the bus-mapped interrupt controller.
package irq_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned MAX_SRC = 8;
    localparam int unsigned IDX_W   = 3;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 8'hE0;

    localparam logic [1:0] OFS_ENABLE  = 2'd0;
    localparam logic [1:0] OFS_PENDING = 2'd1;
    localparam logic [1:0] OFS_VECTOR  = 2'd2;
    localparam logic [1:0] OFS_EOI     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAISE   = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    typedef struct packed {
        logic              oe;
        logic [DATA_W-1:0] data;
    } rd_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [MAX_SRC-1:0] req_pad;

    assign req_pad = MAX_SRC'(req);

    // Scan from farthest to nearest offset so the nearest hit wins.
    always_comb begin
        logic [IDX_W:0] idx;
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (IDX_W+1)'(ptr) + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(N)) begin
                idx = idx - (IDX_W+1)'(N);
            end
            if (req_pad[idx[IDX_W-1:0]]) begin
                grant = idx[IDX_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched pending, enable mask, round-robin raise/ack to the CPU,
// in-service hold until EOI; registers decoded at BASE_ADDR..BASE_ADDR+3.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned       N_SRC     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] BUS_ADDR,
    inout  wire  [DATA_W-1:0] BUS_DATA,
    input  logic              BUS_WE,
    input  logic [N_SRC-1:0]  SRC_IRQ,
    output logic [N_SRC-1:0]  SRC_ACK,
    output logic              CPU_IRQ,
    input  logic              CPU_ACK
);

    irq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  vector_q, vector_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0]  enable_q, enable_d;
    logic [N_SRC-1:0]  pending_q, prev_q;
    logic [N_SRC-1:0]  src_ack_q;
    logic              cpu_irq_q;
    rd_resp_t          rd_q;

    logic [ADDR_W-1:0] ofs_full;
    logic [1:0]        ofs;
    logic              hit, bus_wr, bus_rd, eoi_wr, ack_fire;
    logic [DATA_W-1:0] unused_bus;
    logic [N_SRC-1:0]  wr_bits, rise, w1c, pend_keep, vec_mask, eligible;
    logic [DATA_W-1:0] rd_mux;
    logic [IDX_W-1:0]  arb_grant;
    logic              arb_valid;

    // Address decode; subtraction keeps the window correct for unaligned bases.
    assign ofs_full   = BUS_ADDR - BASE_ADDR;
    assign hit        = ofs_full < ADDR_W'(4);
    assign ofs        = ofs_full[1:0];
    assign bus_wr     = hit & BUS_WE;
    assign bus_rd     = hit & ~BUS_WE;
    assign eoi_wr     = bus_wr && (ofs == OFS_EOI);
    assign unused_bus = BUS_DATA;
    assign wr_bits    = BUS_DATA[N_SRC-1:0];

    assign rise      = SRC_IRQ & ~prev_q;
    assign w1c       = (bus_wr && (ofs == OFS_PENDING)) ? wr_bits : '0;
    assign enable_d  = (bus_wr && (ofs == OFS_ENABLE)) ? wr_bits : enable_q;
    assign pend_keep = (pending_q & ~w1c) | rise;
    assign vec_mask  = N_SRC'(1) << vector_q;
    assign eligible  = pending_q & enable_q;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            vector_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            vector_q <= vector_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // A raise is withdrawn if its pending or enable bit will be gone after this edge.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        rr_ptr_d = rr_ptr_q;
        ack_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    vector_d = arb_grant;
                    state_d  = ST_RAISE;
                end
            end
            ST_RAISE: begin
                if (!(|(pend_keep & vec_mask)) || !(|(enable_d & vec_mask))) begin
                    state_d = ST_IDLE;
                end else if (CPU_ACK) begin
                    ack_fire = 1'b1;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) begin
                    rr_ptr_d = (vector_q == IDX_W'(N_SRC - 1)) ? '0 : vector_q + IDX_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (ofs)
            OFS_ENABLE:  rd_mux = DATA_W'(enable_q);
            OFS_PENDING: rd_mux = DATA_W'(pending_q);
            OFS_VECTOR:  rd_mux = DATA_W'(vector_q);
            default:     rd_mux = '0;
        endcase
    end

    // New edges win over both W1C and the ack-time clear.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            enable_q  <= '1;
            pending_q <= '0;
            prev_q    <= '0;
            src_ack_q <= '0;
            cpu_irq_q <= 1'b0;
            rd_q      <= '0;
        end else begin
            enable_q  <= enable_d;
            pending_q <= (pend_keep & ~(ack_fire ? vec_mask : '0)) | rise;
            prev_q    <= SRC_IRQ;
            src_ack_q <= ack_fire ? vec_mask : '0;
            cpu_irq_q <= (state_d == ST_RAISE);
            rd_q      <= '{oe: bus_rd, data: rd_mux};
        end
    end

    assign SRC_ACK  = src_ack_q;
    assign CPU_IRQ  = cpu_irq_q;
    assign BUS_DATA = rd_q.oe ? rd_q.data : 'z;

endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller against a cycle-level reference model.
module tb_irq_controller;

    localparam int unsigned N    = 4;
    localparam logic [7:0]  BASE = 8'hE0;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [3:0] src_irq;
    logic       cpu_ack;
    logic       tb_oe;
    logic [7:0] tb_dout;
    wire  [7:0] bus_data;
    wire  [3:0] src_ack;
    wire        cpu_irq;

    int tests = 0;
    int fails = 0;

    // Released bus floats high so a non-driving DUT reads as 8'hFF.
    assign bus_data = tb_oe ? tb_dout : 8'bz;
    pullup (bus_data);

    irq_controller #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .BUS_ADDR (bus_addr),
        .BUS_DATA (bus_data),
        .BUS_WE   (bus_we),
        .SRC_IRQ  (src_irq),
        .SRC_ACK  (src_ack),
        .CPU_IRQ  (cpu_irq),
        .CPU_ACK  (cpu_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase 0 = nothing raised, 1 = raised to CPU, 2 = in service.
    int         m_phase, m_vec, m_ptr;
    logic [3:0] m_pend, m_en, m_prev, m_ack;
    logic       m_irq, m_rd_oe;
    logic [7:0] m_rd_data;

    task automatic model_edge();
        logic [7:0] o8;
        int         ofs;
        bit         hit, fire, found;
        logic [3:0] rise, clr, keep, en_new;
        if (!rst_n) begin
            m_phase = 0; m_vec = 0; m_ptr = 0;
            m_pend = 4'h0; m_en = 4'hF; m_prev = 4'h0; m_ack = 4'h0;
            m_irq = 1'b0; m_rd_oe = 1'b0; m_rd_data = 8'h00;
            return;
        end
        o8  = bus_addr - BASE;
        ofs = int'(o8);
        hit = ofs < 4;
        m_rd_oe = hit && !bus_we;
        case (ofs)
            0:       m_rd_data = {4'h0, m_en};
            1:       m_rd_data = {4'h0, m_pend};
            2:       m_rd_data = 8'(m_vec);
            default: m_rd_data = 8'h00;
        endcase
        rise   = src_irq & ~m_prev;
        clr    = (hit && bus_we && ofs == 1) ? bus_data[3:0] : 4'h0;
        en_new = (hit && bus_we && ofs == 0) ? bus_data[3:0] : m_en;
        keep   = (m_pend & ~clr) | rise;
        fire   = 0;
        if (m_phase == 0) begin
            found = 0;
            for (int k = 0; k < int'(N); k++) begin
                int s = (m_ptr + k) % int'(N);
                if (!found && m_pend[s] && m_en[s]) begin
                    found = 1;
                    m_vec = s;
                end
            end
            if (found) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!keep[m_vec] || !en_new[m_vec]) m_phase = 0;
            else if (cpu_ack) begin
                fire    = 1;
                m_phase = 2;
            end
        end else if (hit && bus_we && ofs == 3) begin
            m_ptr   = (m_vec + 1) % int'(N);
            m_phase = 0;
        end
        m_ack = fire ? 4'(1 << m_vec) : 4'h0;
        if (fire) keep[m_vec] = 1'b0;
        m_pend = keep | rise;
        m_en   = en_new;
        m_prev = src_irq;
        m_irq  = (m_phase == 1);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] exp_bus;
        @(posedge clk);
        model_edge();
        #1;
        exp_bus = m_rd_oe ? m_rd_data : (tb_oe ? tb_dout : 8'hFF);
        check("cpu_irq_model", 8'(cpu_irq), 8'(m_irq));
        check("src_ack_model", 8'(src_ack), 8'(m_ack));
        check("bus_data_model", bus_data, exp_bus);
    endtask

    task automatic bus_idle();
        bus_addr = 8'h00;
        bus_we   = 1'b0;
        tb_oe    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ofs, input logic [7:0] d);
        bus_addr = BASE + 8'(ofs);
        bus_we   = 1'b1;
        tb_oe    = 1'b1;
        tb_dout  = d;
        tick();
        bus_idle();
    endtask

    task automatic rd(input logic [1:0] ofs, output logic [7:0] d);
        bus_addr = BASE + 8'(ofs);
        bus_we   = 1'b0;
        tb_oe    = 1'b0;
        tick();
        d = bus_data;
        bus_idle();
        tick();
        check("bus_release", bus_data, 8'hFF);
    endtask

    initial begin
        logic [7:0] d;
        bit         last_rd;
        rst_n = 1'b0; src_irq = 4'h0; cpu_ack = 1'b0; tb_dout = 8'h00;
        bus_idle();

        // Reset and register reset values
        tick(); tick();
        check("reset_cpu_irq", 8'(cpu_irq), 8'h00);
        rst_n = 1'b1;
        rd(2'd0, d); check("rd_enable_reset", d, 8'h0F);
        rd(2'd1, d); check("rd_pending_reset", d, 8'h00);

        // Single source 1: latency, ack, vector, EOI
        src_irq = 4'b0010;
        tick();
        check("irq_before_pend", 8'(cpu_irq), 8'h00);
        rd(2'd1, d); check("pending_src1", d, 8'h02);
        check("irq_raised_src1", 8'(cpu_irq), 8'h01);
        tick(); tick();
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("ack_src1", 8'(src_ack), 8'h02);
        check("irq_drop_on_ack", 8'(cpu_irq), 8'h00);
        tick();
        check("ack_one_cycle", 8'(src_ack), 8'h00);
        rd(2'd1, d); check("pending_after_ack", d, 8'h00);
        rd(2'd2, d); check("vector_src1", d, 8'h01);
        wr(2'd3, 8'h00);

        // Sources 0 and 3 together with pointer at 2
        src_irq = 4'b1011;
        tick(); tick();
        rd(2'd2, d); check("vector_rr_first", d, 8'h03);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("ack_src3", 8'(src_ack), 8'h08);
        wr(2'd3, 8'h55);
        tick();
        check("eoi_reraise", 8'(cpu_irq), 8'h01);
        rd(2'd2, d); check("vector_rr_second", d, 8'h00);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("ack_src0", 8'(src_ack), 8'h01);
        wr(2'd3, 8'h00);

        // Masked source stays pending until enabled
        wr(2'd0, 8'h0E);
        src_irq = 4'b0000; tick();
        src_irq = 4'b0001; tick(); tick();
        rd(2'd1, d); check("masked_pending", d, 8'h01);
        check("masked_no_irq", 8'(cpu_irq), 8'h00);
        wr(2'd0, 8'h0F);
        tick();
        check("enable_raise", 8'(cpu_irq), 8'h01);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("ack_enabled_src0", 8'(src_ack), 8'h01);
        wr(2'd3, 8'h00);

        // W1C withdraws a raise; same-cycle ack is ignored
        src_irq = 4'b0000; tick();
        src_irq = 4'b0100; tick(); tick();
        check("raise_src2", 8'(cpu_irq), 8'h01);
        cpu_ack = 1'b1;
        wr(2'd1, 8'h04);
        cpu_ack = 1'b0;
        check("w1c_abort_irq", 8'(cpu_irq), 8'h00);
        check("w1c_abort_no_ack", 8'(src_ack), 8'h00);
        tick();
        check("w1c_idle", 8'(cpu_irq), 8'h00);

        // Edge simultaneous with W1C keeps the raise alive
        src_irq = 4'b0000; tick();
        src_irq = 4'b0100; tick(); tick();
        src_irq = 4'b0000; tick();
        src_irq = 4'b0100;
        wr(2'd1, 8'h04);
        check("set_beats_w1c_irq", 8'(cpu_irq), 8'h01);
        rd(2'd1, d); check("set_beats_w1c_pend", d, 8'h04);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("ack_src2", 8'(src_ack), 8'h04);

        // Reset while in service
        src_irq = 4'b0000; tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("reset_in_service_irq", 8'(cpu_irq), 8'h00);
        rd(2'd0, d); check("reset_enable", d, 8'h0F);
        rd(2'd1, d); check("reset_pending", d, 8'h00);
        rd(2'd2, d); check("reset_vector", d, 8'h00);
        wr(2'd3, 8'h00);
        tick();
        check("eoi_after_reset_ignored", 8'(cpu_irq), 8'h00);
        src_irq = 4'b0010; tick(); tick();
        check("raise_after_reset", 8'(cpu_irq), 8'h01);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("ack_after_reset", 8'(src_ack), 8'h02);
        wr(2'd3, 8'h00);

        // Randomized traffic against the model
        last_rd = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            bus_idle();
            rst_n   = 1'b1;
            cpu_ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) src_irq = src_irq ^ 4'(1 << $urandom_range(0, 3));
            if (!last_rd && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0:       bus_addr = BASE + 8'd4;
                    1:       bus_addr = BASE - 8'd1;
                    default: bus_addr = BASE + 8'($urandom_range(0, 3));
                endcase
                bus_we = 1'($urandom_range(0, 1));
                if (bus_we) begin
                    tb_oe   = 1'b1;
                    tb_dout = 8'($urandom);
                end
            end
            last_rd = (bus_addr != 8'h00) && !bus_we;
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller on the main 8-bit bus.
- Collects up to N_SRC peripheral interrupt requests (timer, mouse, others), latches them as pending and masks them through a bus register.
- Picks one request by round-robin and presents it to the Processor on a single raise/ack pair.
- Holds the in-service source until software writes end-of-interrupt (EOI). Processor ISR reads VECTOR to identify the source.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8).
- BASE_ADDR, 8'hE0, bus address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-low reset
- BUS_ADDR  input  8  main bus address
- BUS_DATA  inout  8  main bus data; tri-stated unless this block is returning read data
- BUS_WE  input  1  main bus write enable
- SRC_IRQ  input  N_SRC  peripheral requests; rising edge = new request
- SRC_ACK  output  N_SRC  one-cycle acknowledge pulse to the granted source
- CPU_IRQ  output  1  interrupt raise to Processor
- CPU_ACK  input  1  interrupt acknowledge from Processor (one-cycle pulse)

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - CPU_IRQ=0, SRC_ACK=0, BUS_DATA=Z.
  - PENDING=0, ENABLE=all ones, VECTOR=0, rr pointer=0, state=IDLE, edge history=0.
  - Reset mid-operation abandons any raise or service with no SRC_ACK pulse.
- Register map (offset from BASE_ADDR):
  - +0 ENABLE: RW, bit i=1 enables source i.
  - +1 PENDING: R; write-1-to-clear.
  - +2 VECTOR: R, index of the source raised or in service.
  - +3 EOI: write of any value ends service.
  - Bits at or above N_SRC read 0 and ignore writes.
- Bus reads:
  - A CLK edge with address in range and BUS_WE=0 registers the read data and an output enable.
  - BUS_DATA is driven for the following cycle only (one-cycle latency), then returns to Z.
  - Writes take effect at the edge where BUS_WE=1.
- Edge capture: pending[i] is set at the edge where SRC_IRQ[i]=1 and its registered previous value was 0.
  - Set beats a simultaneous W1C clear.
  - A level held high sets pending only once.
- Eligible vector = PENDING & ENABLE.
- State machine:
  - IDLE: if eligible≠0, pick the first eligible index at or after rr pointer (wrapping modulo N_SRC), load VECTOR, go to RAISE.
  - RAISE: CPU_IRQ=1 (registered).
    - On CPU_ACK=1: clear pending[VECTOR], pulse SRC_ACK[VECTOR] for one cycle, drop CPU_IRQ, go to SERVICE.
    - If pending[VECTOR] is cleared by W1C, or enable[VECTOR] is cleared, before the ack: drop CPU_IRQ, go to IDLE, no SRC_ACK.
    - A CPU_ACK in that same cycle is ignored.
  - SERVICE: CPU_IRQ=0; new edges still latch into pending, including the in-service source.
    - On an EOI write: rr pointer=(VECTOR+1) mod N_SRC, go to IDLE.
- EOI writes in IDLE or RAISE are ignored. CPU_ACK outside RAISE is ignored.
- Latency:
  - Edge sampled at cycle k: pending visible at k+1, CPU_IRQ high at k+2 (block idle, source enabled).
  - EOI at cycle m with another request pending: CPU_IRQ high again at m+2.
- Only one interrupt is outstanding at a time; no nesting.

Decomposition:
- Shared package irq_pkg:
  - Register offsets: OFS_ENABLE=0, OFS_PENDING=1, OFS_VECTOR=2, OFS_EOI=3.
  - State encoding IDLE/RAISE/SERVICE (2 bits).
  - Default BASE_ADDR constant.
- Sub-module rr_arbiter, parameter N:
  - Inputs: request vector, pointer.
  - Outputs: grant index, valid.
  - Purely combinational, instantiated once.

Test Plan:
- Reset held 2 cycles, then read +0 and +1 -> read data 8'h0F then 8'h00 on the cycle after each address; BUS_DATA=Z otherwise; CPU_IRQ=0.
- SRC_IRQ[1] rises at cycle 10 -> PENDING=8'h02 at 11; CPU_IRQ=1 at 12; CPU_ACK at 15 -> SRC_ACK=4'b0010 for one cycle, PENDING=0; VECTOR reads 1; EOI write -> IDLE, rr pointer=2.
- SRC_IRQ[0] and [3] rise together, pointer=2 -> VECTOR=3 first; after ack+EOI, VECTOR=0 next; each source gets exactly one SRC_ACK pulse.
- ENABLE written 8'h0E, SRC_IRQ[0] rises -> PENDING=8'h01, CPU_IRQ stays 0. Writing ENABLE=8'h0F -> CPU_IRQ=1 two cycles later.
- In RAISE for source 2, write PENDING=8'h04 (W1C) -> CPU_IRQ drops next cycle, state IDLE, no SRC_ACK. Edge on source 2 in the same cycle as the W1C -> pending stays set, raise continues.
- RESET=0 during SERVICE -> next cycle: all registers at reset values, CPU_IRQ=0. A later EOI write is ignored; a new edge is raised normally.
